// File: rtl/ev20_pc_unit_if.sv
// ev20_pc_unit_if: decoder-to-PC-unit control strobes/targets and PC/return-stack status.
// master = instruction decoder side, slave = PC unit.
interface ev20_pc_unit_if #(parameter int AW = 11, parameter int DEPTH = 4);
   localparam int DW = $clog2(DEPTH) + 1;
   logic          stall, jump, branch, call, ret;
   logic [AW-1:0] jump_addr, branch_off, pc;
   logic          stack_full, stack_empty, stack_err;
   logic [DW-1:0] depth_cnt;
   modport master (
      output stall, jump, jump_addr, branch, branch_off, call, ret,
      input  pc, stack_full, stack_empty, stack_err, depth_cnt
   );
   modport slave (
      input  stall, jump, jump_addr, branch, branch_off, call, ret,
      output pc, stack_full, stack_empty, stack_err, depth_cnt
   );
endinterface

// File: rtl/ev20_pc_unit.sv
// ev20_pc_unit: EV20 program counter with relative branch, stall and call/return stack.
// Define EV20_PC_TRAP_EN to redirect stack overflow/underflow to TRAP_VECTOR.
module ev20_pc_unit #(
   parameter int            AW          = 11,
   parameter int            DEPTH       = 4,
   parameter logic [AW-1:0] RESET_PC    = '0,
   parameter logic [AW-1:0] TRAP_VECTOR = AW'(2047)
) (
   input logic            clk,
   input logic            res,
   ev20_pc_unit_if.slave  bus
);
   localparam int PW = $clog2(DEPTH);
   localparam int DW = PW + 1;
   logic [AW-1:0] stack_q [DEPTH];
   logic [AW-1:0] pc_q, pc_d, pc_inc, err_pc, top;
   logic [DW-1:0] depth_q, depth_d;
   logic          err_q, err_d, push, empty, full;
   assign pc_inc = pc_q + AW'(1);
   assign empty  = depth_q == '0;
   assign full   = depth_q == DW'(DEPTH);
   assign top    = stack_q[PW'(depth_q - DW'(1))];
`ifdef EV20_PC_TRAP_EN
   assign err_pc = TRAP_VECTOR;
`else
   logic unused_trap;
   assign unused_trap = ^TRAP_VECTOR;
   assign err_pc      = pc_inc;
`endif
   always_comb begin
      pc_d    = pc_inc;
      depth_d = depth_q;
      err_d   = err_q;
      push    = 1'b0;
      if (bus.stall) begin
         pc_d = pc_q;
      end else if (bus.ret) begin
         err_d   = err_q | empty;
         pc_d    = empty ? err_pc : top;
         depth_d = empty ? depth_q : depth_q - DW'(1);
      end else if (bus.call) begin
         err_d   = err_q | full;
         push    = !full;
         pc_d    = full ? err_pc : bus.jump_addr;
         depth_d = full ? depth_q : depth_q + DW'(1);
      end else if (bus.jump) begin
         pc_d = bus.jump_addr;
      end else if (bus.branch) begin
         pc_d = pc_q + bus.branch_off;
      end
   end
   always_ff @(posedge clk) begin
      if (res) begin
         pc_q    <= RESET_PC;
         depth_q <= '0;
         err_q   <= 1'b0;
      end else begin
         pc_q    <= pc_d;
         depth_q <= depth_d;
         err_q   <= err_d;
      end
   end
   // Return addresses need no reset: occupancy alone decides what is valid.
   always_ff @(posedge clk) begin
      if (push && !res) stack_q[depth_q[PW-1:0]] <= pc_inc;
   end
   assign bus.pc          = pc_q;
   assign bus.depth_cnt   = depth_q;
   assign bus.stack_full  = full;
   assign bus.stack_empty = empty;
   assign bus.stack_err   = err_q;
endmodule

// File: tb/tb_ev20_pc_unit.sv
// tb_ev20_pc_unit: scoreboard bench; a queue-based stack model predicts each cycle's PC/status.
module tb_ev20_pc_unit;
   localparam int AW = 11;
   localparam int DEPTH = 4;
   localparam logic [AW-1:0] RESET_PC = '0;
   localparam logic [AW-1:0] TRAP = 11'd2047;
   typedef struct {
      logic [AW-1:0] pc;
      logic [2:0]    d;
      logic          f, e, er;
   } exp_t;
   logic clk = 1'b0, res = 1'b0;
   int n_chk = 0, n_pass = 0;
   exp_t sb[$];
   logic [AW-1:0] m_pc;
   logic [AW-1:0] m_stk[$];
   logic m_err;
   ev20_pc_unit_if #(.AW(AW), .DEPTH(DEPTH)) bus ();
   ev20_pc_unit #(.AW(AW), .DEPTH(DEPTH), .RESET_PC(RESET_PC), .TRAP_VECTOR(TRAP)) dut (
      .clk(clk), .res(res), .bus(bus)
   );
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
   endtask
   function automatic logic [AW-1:0] err_target(input logic [AW-1:0] p);
`ifdef EV20_PC_TRAP_EN
      return TRAP;
`else
      return p + 11'd1;
`endif
   endfunction
   task automatic cyc(input logic r, input logic s, input logic j, input logic [AW-1:0] ja,
                      input logic b, input logic [AW-1:0] bo, input logic c, input logic rt);
      exp_t e, o;
      @(negedge clk);
      res = r; bus.stall = s; bus.jump = j; bus.jump_addr = ja;
      bus.branch = b; bus.branch_off = bo; bus.call = c; bus.ret = rt;
      if (r) begin
         m_pc = RESET_PC; m_stk.delete(); m_err = 1'b0;
      end else if (s) begin
      end else if (rt) begin
         if (m_stk.size() == 0) begin m_err = 1'b1; m_pc = err_target(m_pc); end
         else m_pc = m_stk.pop_back();
      end else if (c) begin
         if (m_stk.size() == DEPTH) begin m_err = 1'b1; m_pc = err_target(m_pc); end
         else begin m_stk.push_back(m_pc + 11'd1); m_pc = ja; end
      end else if (j) m_pc = ja;
      else if (b) m_pc = m_pc + bo;
      else m_pc = m_pc + 11'd1;
      e.pc = m_pc; e.d = 3'(m_stk.size()); e.f = m_stk.size() == DEPTH;
      e.e = m_stk.size() == 0; e.er = m_err;
      sb.push_back(e);
      @(posedge clk);
      #1;
      o = sb.pop_front();
      chk("pc", 32'(bus.pc), 32'(o.pc));
      chk("depth", 32'(bus.depth_cnt), 32'(o.d));
      chk("full", 32'(bus.stack_full), 32'(o.f));
      chk("empty", 32'(bus.stack_empty), 32'(o.e));
      chk("err", 32'(bus.stack_err), 32'(o.er));
   endtask
   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0, 0);
   endtask
   task automatic jmp(input logic [AW-1:0] a);  cyc(0, 0, 1, a, 0, 0, 0, 0); endtask
   task automatic brn(input logic [AW-1:0] o);  cyc(0, 0, 0, 0, 1, o, 0, 0); endtask
   task automatic cal(input logic [AW-1:0] a);  cyc(0, 0, 0, a, 0, 0, 1, 0); endtask
   task automatic rtn();                        cyc(0, 0, 0, 0, 0, 0, 0, 1); endtask
   task automatic rst();                        cyc(1, 0, 0, 0, 0, 0, 0, 0); endtask
   initial begin
      bus.stall = 0; bus.jump = 0; bus.jump_addr = 0; bus.branch = 0;
      bus.branch_off = 0; bus.call = 0; bus.ret = 0;
      m_pc = '0; m_err = 1'b0;
      rst();
      chk("rst_pc", 32'(bus.pc), 0);
      chk("rst_empty", 32'(bus.stack_empty), 1);
      idle(3);
      chk("run_pc3", 32'(bus.pc), 3);
      jmp(11'd2047); idle(1);
      chk("wrap", 32'(bus.pc), 0);
      jmp(11'd100); brn(11'h7FC);
      chk("br_neg", 32'(bus.pc), 96);
      jmp(11'd2046); brn(11'd5);
      chk("br_wrap", 32'(bus.pc), 3);
      jmp(11'd10); cal(11'd20); cal(11'd30); cal(11'd40);
      chk("nest_depth", 32'(bus.depth_cnt), 3);
      rtn(); chk("ret1", 32'(bus.pc), 31);
      rtn(); chk("ret2", 32'(bus.pc), 21);
      rtn(); chk("ret3", 32'(bus.pc), 11);
      chk("nest_empty", 32'(bus.stack_empty), 1);
      chk("nest_err", 32'(bus.stack_err), 0);
      cal(11'd100); cal(11'd200); cal(11'd300); cal(11'd50);
      chk("ovf_full", 32'(bus.stack_full), 1);
      chk("ovf_pc50", 32'(bus.pc), 50);
      cal(11'd500);
`ifdef EV20_PC_TRAP_EN
      chk("ovf_pc", 32'(bus.pc), 2047);
`else
      chk("ovf_pc", 32'(bus.pc), 51);
`endif
      chk("ovf_err", 32'(bus.stack_err), 1);
      chk("ovf_depth", 32'(bus.depth_cnt), 4);
      rst(); jmp(11'd7); rtn();
`ifdef EV20_PC_TRAP_EN
      chk("unf_pc", 32'(bus.pc), 2047);
`else
      chk("unf_pc", 32'(bus.pc), 8);
`endif
      chk("unf_err", 32'(bus.stack_err), 1);
      idle(10);
      chk("sticky", 32'(bus.stack_err), 1);
      rst();
      chk("err_clr", 32'(bus.stack_err), 0);
      jmp(11'd400); cyc(0, 1, 1, 11'd900, 0, 0, 0, 0);
      chk("stall_hold", 32'(bus.pc), 400);
      jmp(11'd299); cal(11'd600);
      cyc(0, 0, 0, 11'd700, 0, 0, 1, 1);
      chk("ret_over_call", 32'(bus.pc), 300);
      chk("ret_depth", 32'(bus.depth_cnt), 0);
      cal(11'd800); cal(11'd900);
      cyc(1, 0, 0, 11'd123, 0, 0, 1, 0);
      chk("res_call_pc", 32'(bus.pc), 0);
      chk("res_call_depth", 32'(bus.depth_cnt), 0);
      for (int i = 0; i < 300; i++)
         cyc($urandom_range(0, 40) == 0, $urandom_range(0, 7) == 0, $urandom_range(0, 5) == 0,
             AW'($urandom), $urandom_range(0, 3) == 0, AW'($urandom),
             $urandom_range(0, 4) == 0, $urandom_range(0, 4) == 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/ev20_pc_unit.md
Name: ev20_pc_unit

Overview:
- Parametrised next-generation program counter for the EV20 core.
- Adds relative branch, stall, and a hardware call/return stack to the increment/preload/reset behaviour.
- Sits between the instruction decoder, which supplies the control strobes and targets, and the instruction memory address port, which consumes `pc`.
- Reports stack status and errors to the control unit.

Parameters:
- AW, 11, PC/address width in bits (min 4).
- DEPTH, 4, return-stack entries (power of 2, min 2).
- RESET_PC, 0, PC value loaded on reset (AW bits).
- TRAP_VECTOR, 2047, PC loaded on stack error when the optional feature is enabled.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- res  in  1  reset, synchronous, active-high.
- stall  in  1  hold PC and stack unchanged this cycle.
- jump  in  1  absolute load: PC <= jump_addr.
- jump_addr  in  AW  absolute target for jump/call.
- branch  in  1  relative branch: PC <= PC + sign-extended branch_off.
- branch_off  in  AW  two's-complement offset.
- call  in  1  push PC+1, then PC <= jump_addr.
- ret  in  1  pop top of stack into PC.
- pc  out  AW  current program counter (registered).
- stack_full  out  1  stack holds DEPTH entries.
- stack_empty  out  1  stack holds 0 entries.
- stack_err  out  1  sticky overflow/underflow flag.
- depth_cnt  out  clog2(DEPTH)+1  current stack occupancy.

Behaviour:
- Reset, when res=1 at an edge:
  - pc=RESET_PC, depth_cnt=0, stack_empty=1, stack_full=0, stack_err=0.
  - Stack contents are don't-care.
  - Reset overrides every other input, including mid-call or mid-stall.
- Update priority per edge: res > stall > ret > call > jump > branch > increment. Only the highest-priority active request takes effect; lower ones are ignored that cycle.
- stall=1: pc, stack, and flags all hold.
- ret:
  - Stack non-empty: pc <= top entry; depth_cnt decrements.
  - Stack empty (underflow): stack_err <= 1; pc <= pc+1; depth unchanged.
- call:
  - Stack not full: push pc+1 (mod 2^AW); pc <= jump_addr; depth_cnt increments.
  - Stack full (overflow): no push; stack_err <= 1; pc <= pc+1 (target not taken).
- jump: pc <= jump_addr.
- branch: pc <= (pc + branch_off) mod 2^AW. Wrap in both directions, no flag.
- Increment: pc <= pc+1. 2^AW-1 wraps to 0.
- Latency: the new pc is visible one cycle after the strobe edge. There is no combinational path from inputs to pc.
- Flags:
  - stack_full = (depth_cnt==DEPTH); stack_empty = (depth_cnt==0). Both are derived from registered depth_cnt.
  - stack_err is sticky and clears only on res.
- The stack is LIFO. The storage pointer is implicit in depth_cnt (top = depth_cnt-1).

Optional Feature:
- Macro: EV20_PC_TRAP_EN.
- Defined: on overflow/underflow, pc <= TRAP_VECTOR instead of pc+1. Flag and stack behaviour are unchanged.
- Undefined: pc <= pc+1 on error as above, and TRAP_VECTOR is unused.

Test Plan:
- Reset then free-run (AW=11, RESET_PC=0):
  - pc reads 0 on the cycle after reset, then 1, 2, 3.
  - Force pc=2047 via jump; next cycle pc=0 (wrap).
- Branch:
  - pc=100, branch_off=0x7FC (-4) -> pc=96.
  - pc=2046, branch_off=5 -> pc=3.
- Call/return nesting, DEPTH=4:
  - Calls at pc=10, 20, 30 with jump_addr 20, 30, 40 -> depth_cnt=3.
  - Three rets -> pc 31, 21, 11, then stack_empty=1, stack_err=0.
- Overflow:
  - 4 calls fill the stack (stack_full=1).
  - 5th call at pc=50 -> pc=51 (or TRAP_VECTOR with EV20_PC_TRAP_EN), stack_err=1, depth_cnt stays 4.
- Underflow and sticky flag:
  - ret on empty at pc=7 -> pc=8, stack_err=1.
  - stack_err stays 1 through 10 cycles of normal counting; clears only on res=1.
- Priority and stall:
  - stall=1 with jump=1 -> pc holds.
  - ret and call together with depth_cnt=1 and top=300 -> pc=300, depth_cnt=0.
  - res=1 with call=1 -> pc=RESET_PC, depth_cnt=0.
